// File: rtl/display_page_ctrl.sv
// Page selector for the seven-segment scanner: debounces next/prev buttons,
// steps through 8085 register pages and registers the selected byte pair.
module display_page_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       freeze,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg_flags,
  input  logic [7:0] reg_b,
  input  logic [7:0] reg_c,
  input  logic [7:0] reg_d,
  input  logic [7:0] reg_e,
  input  logic [7:0] reg_h,
  input  logic [7:0] reg_l,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] page
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries the next button, bit 1 the prev button.
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [2:0]       page_q, page_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [1:0]       press;

  always_comb begin
    s1_d         = {btn_prev, btn_next};
    s2_d         = s1_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;

  // Simultaneous next and prev cancel; an out-of-range page recovers to 0.
  always_comb begin
    page_d = page_q;
    if (press[0] ^ press[1]) begin
      if (page_q > 3'd5) begin
        page_d = 3'd0;
      end else if (press[0]) begin
        page_d = (page_q == 3'd5) ? 3'd0 : page_q + 3'd1;
      end else begin
        page_d = (page_q == 3'd0) ? 3'd5 : page_q - 3'd1;
      end
    end
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (!freeze) begin
      case (page_q)
        3'd0:    begin a_d = reg_a;     b_d = reg_flags; end
        3'd1:    begin a_d = reg_b;     b_d = reg_c;     end
        3'd2:    begin a_d = reg_d;     b_d = reg_e;     end
        3'd3:    begin a_d = reg_h;     b_d = reg_l;     end
        3'd4:    begin a_d = pc[15:8];  b_d = pc[7:0];   end
        3'd5:    begin a_d = sp[15:8];  b_d = sp[7:0];   end
        default: begin a_d = 8'h00;     b_d = 8'h00;     end
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      page_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      page_q       <= page_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign page = page_q;

endmodule

// File: tb/tb_display_page_ctrl.sv
// Directed bench for display_page_ctrl: the driver queues expected outputs
// tagged with the edge they belong to; a monitor pops and compares them.
module tb_display_page_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_next, btn_prev, freeze;
  logic [7:0]  reg_a, reg_flags, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
  logic [15:0] pc, sp;
  logic [7:0]  a, b;
  logic [2:0]  page;

  typedef struct packed {
    int unsigned cyc;
    int unsigned id;
    logic [2:0]  page;
    logic [7:0]  a;
    logic [7:0]  b;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned next_id = 0;
  int          vectors = 0;
  int          miscompares = 0;

  display_page_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock_100Mhz(clk), .reset(reset),
    .btn_next(btn_next), .btn_prev(btn_prev), .freeze(freeze),
    .reg_a(reg_a), .reg_flags(reg_flags), .reg_b(reg_b), .reg_c(reg_c),
    .reg_d(reg_d), .reg_e(reg_e), .reg_h(reg_h), .reg_l(reg_l),
    .pc(pc), .sp(sp), .a(a), .b(b), .page(page)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect (page, a, b) right after the k-th rising edge from now.
  task automatic expect_in(input int k, input logic [2:0] p,
                           input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    e.cyc  = cyc + k;
    e.id   = next_id;
    e.page = p;
    e.a    = ea;
    e.b    = eb;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    step(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    step(10);
  endtask

  task automatic check_now(input logic [2:0] p, input logic [7:0] ea,
                           input logic [7:0] eb);
    expect_in(1, p, ea, eb);
    step(1);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != cyc || page !== e.page || a !== e.a || b !== e.b) begin
          miscompares++;
          $display("FAIL vec%0d edge%0d: got page=%0d a=%h b=%h, want page=%0d a=%h b=%h (due edge %0d)",
                   e.id, cyc, page, a, b, e.page, e.a, e.b, e.cyc);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; freeze = 1'b0;
    reg_a = 8'h12; reg_flags = 8'h34; reg_b = 8'h56; reg_c = 8'h78;
    reg_d = 8'h9A; reg_e = 8'hBC; reg_h = 8'hDE; reg_l = 8'hF0;
    pc = 16'h1234; sp = 16'hBEEF;

    // Reset edge, then first load of page 0.
    expect_in(1, 3'd0, 8'h00, 8'h00);
    step(1);
    reset = 1'b0;
    check_now(3'd0, 8'h12, 8'h34);
    check_now(3'd0, 8'h12, 8'h34);

    // Held next: page at edge 7, a/b at edge 8, nothing more while held.
    btn_next = 1'b1;
    expect_in(6, 3'd0, 8'h12, 8'h34);
    expect_in(7, 3'd1, 8'h12, 8'h34);
    expect_in(8, 3'd1, 8'h56, 8'h78);
    step(8);
    expect_in(6, 3'd1, 8'h56, 8'h78);
    step(12);
    btn_next = 1'b0;
    step(10);
    check_now(3'd1, 8'h56, 8'h78);

    press(1'b0, 1'b1);
    check_now(3'd0, 8'h12, 8'h34);

    // Bounce: 3 high / 1 low never reaches the debounce threshold.
    for (int r = 0; r < 5; r++) begin
      btn_next = 1'b1;
      for (int j = 0; j < 3; j++) check_now(3'd0, 8'h12, 8'h34);
      btn_next = 1'b0;
      check_now(3'd0, 8'h12, 8'h34);
    end
    step(8);
    check_now(3'd0, 8'h12, 8'h34);

    // Register change shows up one edge later.
    reg_a = 8'h77;
    check_now(3'd0, 8'h77, 8'h34);
    reg_a = 8'h12;
    check_now(3'd0, 8'h12, 8'h34);

    // Wrap both directions.
    press(1'b0, 1'b1);
    check_now(3'd5, 8'hBE, 8'hEF);
    press(1'b1, 1'b0);
    check_now(3'd0, 8'h12, 8'h34);

    press(1'b1, 1'b0);
    check_now(3'd1, 8'h56, 8'h78);
    press(1'b1, 1'b0);
    check_now(3'd2, 8'h9A, 8'hBC);
    press(1'b1, 1'b0);
    check_now(3'd3, 8'hDE, 8'hF0);

    // Reset mid-debounce with next still held: the count restarts.
    btn_next = 1'b1;
    step(4);
    reset = 1'b1;
    expect_in(1, 3'd0, 8'h00, 8'h00);
    step(1);
    reset = 1'b0;
    expect_in(1, 3'd0, 8'h12, 8'h34);
    expect_in(6, 3'd0, 8'h12, 8'h34);
    expect_in(7, 3'd1, 8'h12, 8'h34);
    expect_in(8, 3'd1, 8'h56, 8'h78);
    step(8);
    btn_next = 1'b0;
    step(10);

    // Both buttons together cancel; next alone then advances.
    press(1'b1, 1'b1);
    check_now(3'd1, 8'h56, 8'h78);
    press(1'b1, 1'b0);
    check_now(3'd2, 8'h9A, 8'hBC);
    press(1'b1, 1'b0);
    check_now(3'd3, 8'hDE, 8'hF0);
    press(1'b1, 1'b0);
    check_now(3'd4, 8'h12, 8'h34);

    // Freeze holds a/b while page still moves.
    freeze = 1'b1;
    pc = 16'h5678;
    check_now(3'd4, 8'h12, 8'h34);
    press(1'b1, 1'b0);
    check_now(3'd5, 8'h12, 8'h34);
    freeze = 1'b0;
    check_now(3'd5, 8'hBE, 8'hEF);
    press(1'b1, 1'b0);
    check_now(3'd0, 8'h12, 8'h34);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      miscompares += exp_q.size();
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_page_ctrl.md
Name: display_page_ctrl

Overview:
- Upstream feeder for the four-digit seven-segment scanner; drives its two 8-bit display bytes `a` (left two digits) and `b` (right two digits).
- Lets the user step through 8085 register pages with two raw pushbuttons (next/prev), each fully debounced in this block.
- Registers the selected byte pair so the scanner always sees glitch-free, coherent values.
- Optional freeze holds the shown values while the CPU keeps running.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles required to accept a button level change (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock_100Mhz  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_next  input  1  raw asynchronous pushbutton, high = pressed.
- btn_prev  input  1  raw asynchronous pushbutton, high = pressed.
- freeze  input  1  high = hold current `a`/`b`.
- reg_a, reg_flags, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l  input  8 each  8085 register file values.
- pc  input  16  program counter.
- sp  input  16  stack pointer.
- a  output  8  left display byte, to the scanner's `a` input.
- b  output  8  right display byte, to the scanner's `b` input.
- page  output  3  current page index, 0..5.

Behaviour:
- Reset, sampled on a clock edge with reset=1, clears all of the following to 0:
  - page, a, b;
  - synchronizer flops, stable levels, stable-delay flops, debounce counters.
  - Reset overrides every other input.
  - Reset mid-debounce discards any partial count.
- Page map (a, b):
  - 0: reg_a, reg_flags
  - 1: reg_b, reg_c
  - 2: reg_d, reg_e
  - 3: reg_h, reg_l
  - 4: pc[15:8], pc[7:0]
  - 5: sp[15:8], sp[7:0]
  - Values 6 and 7 are unreachable. If page is ever 6 or 7, a=b=8'h00 and the next accepted press of either button loads page 0.
- Synchronizer: each button passes through two flops (s1, s2) before any use.
- Debounce, one independent instance per button:
  - Holds a stable level and a counter.
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
  - Net effect: stable follows s2 only after DEBOUNCE_CYCLES consecutive mismatching cycles. Any single-cycle agreement restarts the count.
- Press pulse:
  - press = stable & ~stable_d, where stable_d is stable delayed by one cycle.
  - Exactly one cycle wide per accepted press.
  - Release (1→0 on stable) produces no pulse.
  - Holding a button produces no auto-repeat.
- Page update, registered:
  - next pulse only: page wraps 5→0, otherwise +1.
  - prev pulse only: page wraps 0→5, otherwise −1.
  - Both pulses in the same cycle: page unchanged.
- Output register, every cycle:
  - freeze=0: a,b <= map(page) using current register inputs, so register changes appear with 1-cycle latency.
  - freeze=1: a,b hold.
  - page still updates while frozen; a,b reload from the new page on the first edge after freeze falls.
- Latency from raw press:
  - btn goes high before edge 1 and stays high.
  - s2=1 after edge 2; stable=1 after edge 2+N, where N = DEBOUNCE_CYCLES.
  - Pulse is high in the following cycle; page updates at edge 3+N; a/b show the new page at edge 4+N.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset then idle; regs a=12, flags=34 → a=8'h12, b=8'h34, page=0. With reset asserted mid-run from page 3 → page=0 and a,b=0 on the reset edge, then a=12, b=34 one edge after reset deasserts.
- btn_next held 20 cycles; b=56, c=78 → page=1 exactly at edge 7 after assertion, a=56, b=78 at edge 8, then no further change while held or on release.
- Bounce: btn_next toggled high 3 cycles / low 1 cycle, repeated 5×, then low → page stays 0 throughout.
- Wrap: from page 0, one clean btn_prev press → page=5, a=sp[15:8], b=sp[7:0] (sp=16'hBEEF → a=BE, b=EF). Then a clean btn_next press → page=0.
- Both buttons pressed on the same cycle, clean, 10 cycles → pulses coincide and page stays unchanged. Releasing both, then pressing next alone → page +1.
- Page 4, pc=16'h1234, freeze=1; pc changes to 16'h5678 and next is pressed → a,b stay 12,34 and page=5. freeze=0 → next edge a,b = sp bytes.
